// File: rtl/int_mul_pkg.sv
// Shared types and elaboration helpers for the iterative integer multiplier.
package int_mul_pkg;

  typedef enum logic [1:0] {MUL_LO_U, MUL_LO_S, MUL_HI_U, MUL_HI_S} mul_mode_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  // Worst-case number of RUN cycles for a given operand width and radix.
  function automatic int steps(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One radix step: partial product of the multiplicand and the current multiplier
// digit, aligned to the digit's bit position within the double-width accumulator.
module mul_radix_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int SHIFT_W        = 6
) (
  input  logic [WIDTH-1:0]          i_mag_a,
  input  logic [BITS_PER_CYCLE-1:0] i_digit,
  input  logic [SHIFT_W-1:0]        i_shift,
  output logic [2*WIDTH-1:0]        o_partial
);

  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_digit_ext;

  assign w_a_ext     = {{WIDTH{1'b0}}, i_mag_a};
  assign w_digit_ext = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, i_digit};
  assign o_partial   = (w_a_ext * w_digit_ext) << i_shift;

endmodule

// File: rtl/mul_iter_param.sv
// Iterative signed/unsigned multiplier with req/ack pulses, retiring BITS_PER_CYCLE
// multiplier bits per cycle and stopping early once the remaining bits are zero.
module mul_iter_param
  import int_mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ack,
  output logic             busy,
  output logic [WIDTH-1:0] out
);

  localparam int STEPS   = steps(WIDTH, BITS_PER_CYCLE);
  localparam int SHIFT_W = $clog2(WIDTH) + 1;

  mul_state_t r_state, w_state_next;

  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHIFT_W-1:0] r_shift;
  logic [SHIFT_W-1:0] r_step;
  logic               r_sign;
  logic               r_hi;
  logic               r_ack;
  logic               r_busy;
  logic [WIDTH-1:0]   r_out;

  mul_mode_t          w_mode;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_b_next;
  logic [2*WIDTH-1:0] w_partial;
  logic [2*WIDTH-1:0] w_product;
  logic               w_accept;
  logic               w_finish;

  assign w_mode   = mul_mode_t'(mode);
  assign w_signed = (w_mode == MUL_LO_S) || (w_mode == MUL_HI_S);

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign w_mag_a   = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b   = (w_signed && b[WIDTH-1]) ? -b : b;
  assign w_b_next  = r_mag_b >> BITS_PER_CYCLE;
  assign w_product = r_sign ? -r_acc : r_acc;

  mul_radix_step #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE),
    .SHIFT_W       (SHIFT_W)
  ) u_step (
    .i_mag_a  (r_mag_a),
    .i_digit  (r_mag_b[BITS_PER_CYCLE-1:0]),
    .i_shift  (r_shift),
    .o_partial(w_partial)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if ((w_b_next == '0) || (r_step == SHIFT_W'(STEPS - 1))) w_state_next = DONE;
      end
      DONE: begin
        w_finish     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_shift <= '0;
      r_step  <= '0;
      r_sign  <= 1'b0;
      r_hi    <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_ack <= 1'b0;
      if (w_accept) begin
        r_mag_a <= w_mag_a;
        r_mag_b <= w_mag_b;
        r_sign  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_hi    <= mode[1];
        r_acc   <= '0;
        r_shift <= '0;
        r_step  <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == RUN) begin
        r_acc   <= r_acc + w_partial;
        r_mag_b <= w_b_next;
        r_shift <= r_shift + SHIFT_W'(BITS_PER_CYCLE);
        r_step  <= r_step + 1'b1;
      end else if (w_finish) begin
        r_out  <= r_hi ? w_product[2*WIDTH-1:WIDTH] : w_product[WIDTH-1:0];
        r_ack  <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign ack  = r_ack;
  assign busy = r_busy;
  assign out  = r_out;

endmodule

// File: tb/tb_mul_iter_param.sv
// Directed-vector bench for mul_iter_param at WIDTH=32, BITS_PER_CYCLE=2.
module tb_mul_iter_param;
  import int_mul_pkg::*;

  typedef struct {
    mul_mode_t   mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          k;
  } vec_t;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        req  = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] a    = '0;
  logic [31:0] b    = '0;
  logic        ack;
  logic        busy;
  logic [31:0] out;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  mul_iter_param #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .mode(mode),
    .a   (a),
    .b   (b),
    .ack (ack),
    .busy(busy),
    .out (out)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge after the accept edge.
  task automatic applyStimulus(input mul_mode_t m, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    req  = 1'b1;
    mode = m;
    a    = av;
    b    = bv;
    @(negedge clk);
    req  = 1'b0;
  endtask

  // Counts edges after the accept edge until ack is seen, bounded.
  task automatic waitAck(output logic [31:0] got, output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    got   = '0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (ack) begin
        seen = 1'b1;
        got  = out;
      end
    end
  endtask

  vec_t        vecs[12];
  logic [31:0] got;
  int          edges;
  bit          seen;
  int          ackCount;

  initial begin
    vecs[0]  = '{MUL_LO_U, 32'd347911,    32'd12345,      32'hFFFFE88F, 7};
    vecs[1]  = '{MUL_LO_U, 32'd15,        32'd0,          32'h00000000, 1};
    vecs[2]  = '{MUL_LO_U, 32'd0,         32'd15,         32'h00000000, 2};
    vecs[3]  = '{MUL_LO_S, 32'hFFFFFFF9,  32'd3,          32'hFFFFFFEB, 1};
    vecs[4]  = '{MUL_HI_S, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF, 1};
    vecs[5]  = '{MUL_HI_U, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'hFFFFFFFE, 16};
    vecs[6]  = '{MUL_LO_U, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'h00000001, 16};
    vecs[7]  = '{MUL_HI_S, 32'h80000000,  32'h80000000,   32'h40000000, 16};
    vecs[8]  = '{MUL_LO_S, 32'h80000000,  32'h80000000,   32'h00000000, 16};
    vecs[9]  = '{MUL_HI_U, 32'h80000000,  32'h80000000,   32'h40000000, 16};
    vecs[10] = '{MUL_HI_S, 32'h7FFFFFFF,  32'h80000000,   32'hC0000000, 16};
    vecs[11] = '{MUL_LO_U, 32'd150,       32'd40,         32'd6000,     3};

    #12;
    checkOutput("reset ack", {31'd0, ack}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset out", out, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd1);
      waitAck(got, edges, seen);
      if (!seen) begin
        checkOutput($sformatf("vec%0d ack timeout", i), 32'd0, 32'd1);
      end else begin
        checkOutput($sformatf("vec%0d out", i), got, vecs[i].exp);
        checkOutput($sformatf("vec%0d latency", i), 32'(edges), 32'(vecs[i].k + 1));
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d ack low", i), {31'd0, ack}, 32'd0);
        checkOutput($sformatf("vec%0d busy low", i), {31'd0, busy}, 32'd0);
      end
    end

    // A second request while busy must be dropped without a second ack.
    applyStimulus(MUL_LO_U, 32'd347911, 32'd12345);
    @(negedge clk);
    req = 1'b1;
    a   = 32'd1;
    b   = 32'd1;
    @(negedge clk);
    req = 1'b0;
    ackCount = 0;
    got      = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        ackCount++;
        got = out;
      end
    end
    checkOutput("busy-req ack count", 32'(ackCount), 32'd1);
    checkOutput("busy-req out", got, 32'hFFFFE88F);

    // req raised in the ack cycle is accepted on the following edge.
    applyStimulus(MUL_LO_U, 32'd3, 32'd3);
    waitAck(got, edges, seen);
    checkOutput("b2b first out", got, 32'd9);
    req  = 1'b1;
    mode = MUL_LO_U;
    a    = 32'd150;
    b    = 32'd40;
    @(posedge clk);
    #1;
    checkOutput("b2b ack low", {31'd0, ack}, 32'd0);
    checkOutput("b2b busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    waitAck(got, edges, seen);
    if (!seen) checkOutput("b2b ack timeout", 32'd0, 32'd1);
    else begin
      checkOutput("b2b out", got, 32'd6000);
      checkOutput("b2b latency", 32'(edges), 32'd4);
    end

    // Asynchronous reset mid-RUN aborts the operation with no ack.
    applyStimulus(MUL_LO_U, 32'd347911, 32'd12345);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort ack", {31'd0, ack}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort out", out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ackCount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (ack) ackCount++;
    end
    checkOutput("abort stray ack", 32'(ackCount), 32'd0);

    applyStimulus(MUL_LO_U, 32'd3, 32'd5);
    waitAck(got, edges, seen);
    if (!seen) checkOutput("post-reset ack timeout", 32'd0, 32'd1);
    else begin
      checkOutput("post-reset out", got, 32'd15);
      checkOutput("post-reset latency", 32'(edges), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
